fp_multiply_pipe: RTL and testbench

FP_MULTIPLY_PIPE -- requirements
Module: fp_multiply_pipe

---
 rtl/fp_multiply_pipe_if.sv | 31 +++
 rtl/fp_multiply_pipe.sv | 261 ++++++++++++++++++++++++++
 tb/tb_fp_multiply_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_multiply_pipe_if.sv
// Operand/result bundle for fp_multiply_pipe: operand pair in, product plus flags out.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; the multiplier side is the slave modport.
// Signals: in_valid/in_ready, a, b (operands); out_valid/out_ready, c (product), flags.
interface fp_multiply_pipe_if #(
    parameter int EXP_BITS = 5,
    parameter int MAN_BITS = 10
);
    localparam int BITS = 1 + EXP_BITS + MAN_BITS;

    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] c;
    logic [3:0]      flags;   // {invalid, overflow, underflow, inexact}

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, flags
    );

    // The multiplier.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, flags
    );
endinterface

// File: rtl/fp_multiply_pipe.sv
// IEEE-754-format multiplier, RNE rounding, flush-to-zero for subnormal inputs and results.
// Latency: 3 cycles (S1 unpack/exponent sum, S2 significand multiply, S3 normalise/round/pack), 1 result/cycle.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready is the inverse of that stall.
// Ports: clk, rst (async, active-high); io (slave modport): in_valid/in_ready/a/b, out_valid/out_ready/c/flags.
// FP_MUL_FLAGS_EN: when defined, flags = {invalid, overflow, underflow, inexact}; otherwise flags is tied to 0.
module fp_multiply_pipe #(
    parameter int EXP_BITS = 5,
    parameter int MAN_BITS = 10
) (
    input  logic              clk,
    input  logic              rst,
    fp_multiply_pipe_if.slave io
);
    localparam int BITS = 1 + EXP_BITS + MAN_BITS;
    localparam int BIAS = (1 << (EXP_BITS - 1)) - 1;
    localparam int PW   = 2 * (MAN_BITS + 1);
    // Two extra bits hold the un-normalised biased exponent: sums run up to
    // ~2x the max field value and down below zero.
    localparam int EW   = EXP_BITS + 2;

    localparam logic [EXP_BITS-1:0]  EXP_ONES = '1;
    localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_BITS) - 1);
    localparam logic signed [EW-1:0] EXP_MIN  = EW'(1);
    localparam logic [BITS-1:0]      QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_BITS-1){1'b0}}};

    // ------------------------------------------------------------------
    // Handshake: every stage advances together unless the output is stuck.
    // ------------------------------------------------------------------
    logic out_valid_q, out_valid_d;
    logic adv;

    assign adv         = !(out_valid_q && !io.out_ready);
    assign io.in_ready = adv;

    // ------------------------------------------------------------------
    // Operand decode (feeds S1)
    // ------------------------------------------------------------------
    logic                a_sign, b_sign;
    logic [EXP_BITS-1:0] a_exp, b_exp;
    logic [MAN_BITS-1:0] a_man, b_man;
    logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                spc_nan;

    assign a_sign = io.a[BITS-1];
    assign b_sign = io.b[BITS-1];
    assign a_exp  = io.a[BITS-2:MAN_BITS];
    assign b_exp  = io.b[BITS-2:MAN_BITS];
    assign a_man  = io.a[MAN_BITS-1:0];
    assign b_man  = io.b[MAN_BITS-1:0];

    // Exponent field 0 covers both true zero and subnormals (flushed to zero).
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
    assign a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_man != '0);

    assign spc_nan = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);

    // ------------------------------------------------------------------
    // S1: classify, resolve special results early, sum exponents
    // ------------------------------------------------------------------
    logic                 s1_vld_q, s1_vld_d;
    logic                 s1_sign_q, s1_sign_d;
    logic signed [EW-1:0] s1_exp_q, s1_exp_d;
    logic [MAN_BITS-1:0]  s1_man_a_q, s1_man_a_d;
    logic [MAN_BITS-1:0]  s1_man_b_q, s1_man_b_d;
    logic                 s1_spc_q, s1_spc_d;     // result already known, bypasses rounding
    logic [BITS-1:0]      s1_spc_c_q, s1_spc_c_d;

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_man_a_d = s1_man_a_q;
        s1_man_b_d = s1_man_b_q;
        s1_spc_d   = s1_spc_q;
        s1_spc_c_d = s1_spc_c_q;
        if (adv) begin
            s1_vld_d   = io.in_valid;
            s1_sign_d  = a_sign ^ b_sign;
            s1_exp_d   = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_S;
            s1_man_a_d = a_man;
            s1_man_b_d = b_man;
            s1_spc_d   = 1'b0;
            s1_spc_c_d = '0;
            if (spc_nan) begin
                s1_spc_d   = 1'b1;
                s1_spc_c_d = QNAN;
            end else if (a_inf || b_inf) begin
                s1_spc_d   = 1'b1;
                s1_spc_c_d = {a_sign ^ b_sign, EXP_ONES, {MAN_BITS{1'b0}}};
            end else if (a_zero || b_zero) begin
                s1_spc_d   = 1'b1;
                s1_spc_c_d = {a_sign ^ b_sign, {(BITS-1){1'b0}}};
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: full-width significand product (hidden bits restored here)
    // ------------------------------------------------------------------
    logic                 s2_vld_q, s2_vld_d;
    logic                 s2_sign_q, s2_sign_d;
    logic signed [EW-1:0] s2_exp_q, s2_exp_d;
    logic [PW-1:0]        s2_prod_q, s2_prod_d;
    logic                 s2_spc_q, s2_spc_d;
    logic [BITS-1:0]      s2_spc_c_q, s2_spc_c_d;

    always_comb begin
        s2_vld_d   = s2_vld_q;
        s2_sign_d  = s2_sign_q;
        s2_exp_d   = s2_exp_q;
        s2_prod_d  = s2_prod_q;
        s2_spc_d   = s2_spc_q;
        s2_spc_c_d = s2_spc_c_q;
        if (adv) begin
            s2_vld_d   = s1_vld_q;
            s2_sign_d  = s1_sign_q;
            s2_exp_d   = s1_exp_q;
            s2_prod_d  = {{(MAN_BITS+1){1'b0}}, 1'b1, s1_man_a_q}
                       * {{(MAN_BITS+1){1'b0}}, 1'b1, s1_man_b_q};
            s2_spc_d   = s1_spc_q;
            s2_spc_c_d = s1_spc_c_q;
        end
    end

    // ------------------------------------------------------------------
    // S3: normalise, round to nearest even, range check, pack
    // ------------------------------------------------------------------
    logic                 norm;
    logic [MAN_BITS-1:0]  man_t;
    logic                 rnd_g, rnd_r, rnd_s, rnd_up;
    logic [MAN_BITS:0]    man_r;
    logic signed [EW-1:0] exp_n, exp_r;
    logic [BITS-1:0]      res_c;
    logic [BITS-1:0]      c_q, c_d;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); MSB set means [2,4).
        norm = s2_prod_q[PW-1];
        if (norm) begin
            man_t = s2_prod_q[PW-2 -: MAN_BITS];
            rnd_g = s2_prod_q[MAN_BITS];
            rnd_r = s2_prod_q[MAN_BITS-1];
            rnd_s = |s2_prod_q[MAN_BITS-2:0];
        end else begin
            man_t = s2_prod_q[PW-3 -: MAN_BITS];
            rnd_g = s2_prod_q[MAN_BITS-1];
            rnd_r = s2_prod_q[MAN_BITS-2];
            rnd_s = |s2_prod_q[MAN_BITS-3:0];
        end
        exp_n  = s2_exp_q + $signed({{(EW-1){1'b0}}, norm});
        // Ties (g=1, r=s=0) round up only when the kept LSB is odd.
        rnd_up = rnd_g && (rnd_r || rnd_s || man_t[0]);
        man_r  = {1'b0, man_t} + {{MAN_BITS{1'b0}}, rnd_up};
        // Carry-out leaves man_r[MAN_BITS-1:0] all zero, i.e. exactly 1.0 at exp+1.
        exp_r  = exp_n + $signed({{(EW-1){1'b0}}, man_r[MAN_BITS]});

        if (s2_spc_q) begin
            res_c = s2_spc_c_q;
        end else if (exp_r >= EXP_MAX) begin
            res_c = {s2_sign_q, EXP_ONES, {MAN_BITS{1'b0}}};
        end else if (exp_r < EXP_MIN) begin
            res_c = {s2_sign_q, {(BITS-1){1'b0}}};
        end else begin
            res_c = {s2_sign_q, exp_r[EXP_BITS-1:0], man_r[MAN_BITS-1:0]};
        end

        out_valid_d = adv ? s2_vld_q : out_valid_q;
        c_d         = adv ? res_c    : c_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_man_a_q  <= '0;
            s1_man_b_q  <= '0;
            s1_spc_q    <= 1'b0;
            s1_spc_c_q  <= '0;
            s2_vld_q    <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            s2_spc_q    <= 1'b0;
            s2_spc_c_q  <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_man_a_q  <= s1_man_a_d;
            s1_man_b_q  <= s1_man_b_d;
            s1_spc_q    <= s1_spc_d;
            s1_spc_c_q  <= s1_spc_c_d;
            s2_vld_q    <= s2_vld_d;
            s2_sign_q   <= s2_sign_d;
            s2_exp_q    <= s2_exp_d;
            s2_prod_q   <= s2_prod_d;
            s2_spc_q    <= s2_spc_d;
            s2_spc_c_q  <= s2_spc_c_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.c         = c_q;

`ifdef FP_MUL_FLAGS_EN
    // Flag path: special-case flags ride alongside the special result,
    // arithmetic flags are produced in S3 from the rounding bits.
    logic [3:0] s1_flg_q, s1_flg_d;
    logic [3:0] s2_flg_q, s2_flg_d;
    logic [3:0] res_flg;
    logic [3:0] flags_q, flags_d;

    always_comb begin
        s1_flg_d = s1_flg_q;
        s2_flg_d = s2_flg_q;
        if (adv) begin
            s1_flg_d = spc_nan ? 4'b1000 : 4'b0000;
            s2_flg_d = s1_flg_q;
        end

        if (s2_spc_q) begin
            res_flg = s2_flg_q;
        end else if (exp_r >= EXP_MAX) begin
            res_flg = 4'b0101;
        end else if (exp_r < EXP_MIN) begin
            res_flg = 4'b0011;
        end else begin
            res_flg = {3'b000, rnd_g | rnd_r | rnd_s};
        end

        flags_d = adv ? res_flg : flags_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_flg_q <= 4'b0000;
            s2_flg_q <= 4'b0000;
            flags_q  <= 4'b0000;
        end else begin
            s1_flg_q <= s1_flg_d;
            s2_flg_q <= s2_flg_d;
            flags_q  <= flags_d;
        end
    end

    assign io.flags = flags_q;
`else
    assign io.flags = 4'b0000;
`endif

endmodule

// File: tb/tb_fp_multiply_pipe.sv
// Bench for fp_multiply_pipe: half-precision instance under scoreboard, single-precision instance directed.
// Latency: checks 3-cycle accept-to-output where out_ready is held high.
// Backpressure: exercises stalls, reset mid-flight and randomized out_ready.
module tb_fp_multiply_pipe;

`ifdef FP_MUL_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_multiply_pipe_if #(.EXP_BITS(5), .MAN_BITS(10)) h_if ();
    fp_multiply_pipe_if #(.EXP_BITS(8), .MAN_BITS(23)) s_if ();

    fp_multiply_pipe #(.EXP_BITS(5), .MAN_BITS(10)) u_half (
        .clk (clk),
        .rst (rst),
        .io  (h_if)
    );

    fp_multiply_pipe #(.EXP_BITS(8), .MAN_BITS(23)) u_single (
        .clk (clk),
        .rst (rst),
        .io  (s_if)
    );

    typedef struct {
        logic [15:0] c;
        logic [3:0]  f;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: exact integer significand product, rounded by comparing the
    // discarded remainder against half an ULP.
    function automatic void ref_mul(input int E, input int M, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] c,
                                    output logic [3:0] f);
        longint emax, bias, mask, ea, eb, ma, mb, p, q, rem, half, e;
        int     len, sh;
        logic   s, nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
        emax  = (longint'(1) << E) - 1;
        bias  = (longint'(1) << (E - 1)) - 1;
        mask  = (longint'(1) << M) - 1;
        ea    = (longint'(a) >> M) & emax;
        eb    = (longint'(b) >> M) & emax;
        ma    = longint'(a) & mask;
        mb    = longint'(b) & mask;
        s     = a[E+M] ^ b[E+M];
        nan_a = (ea == emax) && (ma != 0);
        nan_b = (eb == emax) && (mb != 0);
        inf_a = (ea == emax) && (ma == 0);
        inf_b = (eb == emax) && (mb == 0);
        zer_a = (ea == 0);
        zer_b = (eb == 0);
        c = '0;
        f = 4'b0000;
        if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a)) begin
            c = 32'((emax << M) | (longint'(1) << (M - 1)));
            f = 4'b1000;
        end else if (inf_a || inf_b) begin
            c = 32'(emax << M);
            c[E+M] = s;
        end else if (zer_a || zer_b) begin
            c[E+M] = s;
        end else begin
            p   = (ma | (longint'(1) << M)) * (mb | (longint'(1) << M));
            len = 0;
            for (int i = 0; i < 63; i++) if (p[i]) len = i + 1;
            e    = ea + eb - bias + longint'(len - 1 - 2 * M);
            sh   = len - (M + 1);
            q    = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << (M + 1))) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= emax) begin
                c = 32'(emax << M);
                c[E+M] = s;
                f = 4'b0101;
            end else if (e <= 0) begin
                c[E+M] = s;
                f = 4'b0011;
            end else begin
                c = 32'((e << M) | (q & mask));
                c[E+M] = s;
                f = {3'b000, rem != 0};
            end
        end
    endfunction

    // Drive an operand pair at the current negedge, wait for in_ready, push expectation.
    task automatic issue_now(input logic [15:0] a, input logic [15:0] b, input bit lat,
                             input bit use_const, input logic [15:0] kc, input logic [3:0] kf);
        exp_t        e;
        logic [31:0] mc;
        logic [3:0]  mf;
        int          w = 0;
        h_if.in_valid = 1'b1;
        h_if.a        = a;
        h_if.b        = b;
        #1;
        while (!h_if.in_ready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 200) chk("accept_timeout", 32'(h_if.in_ready), 32'(1));
        ref_mul(5, 10, {16'h0, a}, {16'h0, b}, mc, mf);
        e.c   = use_const ? kc : mc[15:0];
        e.f   = FLAGS_ON ? (use_const ? kf : mf) : 4'b0000;
        e.cyc = cyc + 3;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit lat);
        @(negedge clk);
        issue_now(a, b, lat, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic issue_k(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] kc, input logic [3:0] kf);
        @(negedge clk);
        issue_now(a, b, 1'b1, 1'b1, kc, kf);
    endtask

    task automatic idle();
        @(negedge clk);
        h_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'(0));
    endtask

    // Monitor: pops and compares on every transfer, checks holding while stalled.
    always begin
        @(negedge clk);
        #1;
        if (!rst && h_if.out_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got c=%h, expected no result", h_if.c);
            end else if (!h_if.out_ready) begin
                chk("stall_in_ready", 32'(h_if.in_ready), 32'(0));
                chk("stall_hold_c", 32'(h_if.c), 32'(exp_q[0].c));
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_c", 32'(h_if.c), 32'(mon_e.c));
                chk("result_flags", 32'(h_if.flags), 32'(mon_e.f));
                if (mon_e.lat) chk("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    function automatic logic [15:0] rnd_h();
        logic [15:0] sp [10];
        logic [15:0] v;
        sp = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E01,
               16'h0001, 16'h3C00, 16'h7BFF, 16'h0400, 16'h83FF};
        case ($urandom_range(0, 7))
            0:       v = sp[$urandom_range(0, 9)];
            1:       v = 16'($urandom);
            default: v = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
        endcase
        return v;
    endfunction

    task automatic s_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] kc, input logic [3:0] kf);
        int w = 0;
        @(negedge clk);
        s_if.in_valid = 1'b1;
        s_if.a        = a;
        s_if.b        = b;
        #1;
        chk("sp_in_ready", 32'(s_if.in_ready), 32'(1));
        @(negedge clk);
        s_if.in_valid = 1'b0;
        #1;
        while (!s_if.out_valid && w < 10) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("sp_out_valid", 32'(s_if.out_valid), 32'(1));
        chk("sp_latency", 32'(w), 32'(2));
        chk("sp_c", s_if.c, kc);
        chk("sp_flags", 32'(s_if.flags), 32'(FLAGS_ON ? kf : 4'b0000));
    endtask

    bit rnd_done;

    initial begin
        logic [31:0] sa, sb, mc;
        logic [3:0]  mf;
        h_if.in_valid  = 1'b0;
        h_if.a         = '0;
        h_if.b         = '0;
        h_if.out_ready = 1'b1;
        s_if.in_valid  = 1'b0;
        s_if.a         = '0;
        s_if.b         = '0;
        s_if.out_ready = 1'b1;
        rst            = 1'b1;
        rnd_done       = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(h_if.out_valid), 32'(0));
        chk("rst_c", 32'(h_if.c), 32'(0));
        chk("rst_flags", 32'(h_if.flags), 32'(0));
        chk("rst_in_ready", 32'(h_if.in_ready), 32'(1));
        chk("rst_sp_out_valid", 32'(s_if.out_valid), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Basic, then three back-to-back, then boundary and special values.
        issue_k(16'h3C00, 16'h3C00, 16'h3C00, 4'b0000);
        idle();
        drain();
        issue_k(16'h4000, 16'h4200, 16'h4600, 4'b0000);
        issue_k(16'hC000, 16'h3800, 16'hBC00, 4'b0000);
        issue_k(16'h3C01, 16'h3C01, 16'h3C02, 4'b0001);
        idle();
        drain();
        issue_k(16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101);
        issue_k(16'h7C00, 16'h0000, 16'h7E00, 4'b1000);
        issue_k(16'h0400, 16'h0400, 16'h0000, 4'b0011);
        issue_k(16'h3E00, 16'h3C01, 16'h3E02, 4'b0001);   // tie, odd LSB rounds up
        issue_k(16'h3E00, 16'h3C03, 16'h3E04, 4'b0001);   // tie, even LSB stays
        issue_k(16'h3DA8, 16'h3DA8, 16'h4000, 4'b0001);   // rounding carries into exponent
        issue_k(16'h0400, 16'h3C00, 16'h0400, 4'b0000);   // smallest normal survives
        issue_k(16'h8400, 16'h3800, 16'h8000, 4'b0011);
        issue_k(16'h7BFF, 16'h3C00, 16'h7BFF, 4'b0000);
        issue_k(16'hFC00, 16'h3C00, 16'hFC00, 4'b0000);
        issue_k(16'h8000, 16'h3C00, 16'h8000, 4'b0000);
        issue_k(16'h7E01, 16'h3C00, 16'h7E00, 4'b1000);
        issue_k(16'h0001, 16'h7C00, 16'h7E00, 4'b1000);   // subnormal acts as zero
        idle();
        drain();

        // Backpressure: out_ready low for 5 cycles while 4 operands are offered.
        fork
            begin
                for (int i = 0; i < 4; i++) issue(rnd_h(), rnd_h(), 1'b0);
                idle();
            end
            begin
                @(negedge clk);
                h_if.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                h_if.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight, one of them stalled at the output.
        h_if.out_ready = 1'b0;
        issue(16'h4000, 16'h4000, 1'b0);
        issue(16'h4200, 16'h4200, 1'b0);
        idle();
        @(negedge clk);
        #1;
        chk("pre_reset_valid", 32'(h_if.out_valid), 32'(1));
        rst = 1'b1;
        #1;
        chk("reset_out_valid", 32'(h_if.out_valid), 32'(0));
        chk("reset_c", 32'(h_if.c), 32'(0));
        chk("reset_in_ready", 32'(h_if.in_ready), 32'(1));
        exp_q.delete();
        h_if.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue_now(16'h3C00, 16'h3C00, 1'b1, 1'b1, 16'h3C00, 4'b0000);
        idle();
        repeat (6) @(negedge clk);
        drain();

        // Randomized operands with random gaps and random out_ready.
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    issue(rnd_h(), rnd_h(), 1'b0);
                    if ($urandom_range(0, 3) == 0) idle();
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    h_if.out_ready = ($urandom_range(0, 3) != 0);
                end
                h_if.out_ready = 1'b1;
            end
        join
        drain();

        // Single precision.
        s_op(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            sa = {1'($urandom), 8'($urandom_range(70, 190)), 23'($urandom)};
            sb = {1'($urandom), 8'($urandom_range(70, 190)), 23'($urandom)};
            ref_mul(8, 23, sa, sb, mc, mf);
            s_op(sa, sb, mc, mf);
        end

        repeat (5) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
